am_insertion_scheduler: RTL and testbench
=========================================

// Module: am_insertion_scheduler
// PURPOSE
//  Sequences alignment-marker (AM) insertion into the 16-lane AUI transmit datapath.
//  Counts data blocks accepted from the upstream source; every AM_PERIOD blocks it
//  pauses the source and grants AM_LEN cycles to the alignment-marker generator/mux.
//  Sits between the PCS block source and the lane distributor; owns o_src_ready.
// PARAMETERS
//  AM_PERIOD  40960              data blocks between consecutive AM bursts (>=2)
//  AM_LEN     16                 AM slots per burst, one per lane (>=2, power of 2)
//  CNT_W      $clog2(AM_PERIOD)  block counter width (derived, do not override)
//  IDX_W      $clog2(AM_LEN)     AM slot index width (derived)
// PORTS
//  clk          in   1      clock (single domain)
//  rst_n        in   1      asynchronous active-low reset
//  i_enable     in   1      level: 1 = run insertion, 0 = idle/flush
//  i_src_valid  in   1      upstream has a data block this cycle
//  o_src_ready  out  1      upstream block accepted when valid&ready
//  i_dst_ready  in   1      downstream (lane distributor) can take a beat
//  o_out_valid  out  1      a beat (data or AM) is presented downstream
//  o_am_sel     out  1      1 = current beat is an AM slot, 0 = data
//  o_am_idx     out  IDX_W  AM slot/lane index within burst
//  o_am_first   out  1      AM slot 0 of a burst
//  o_am_last    out  1      AM slot AM_LEN-1 of a burst
//  o_blk_cnt    out  CNT_W  data blocks sent since last AM burst
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; o_blk_cnt=0, o_am_idx=0;
//    o_src_ready=o_out_valid=o_am_sel=o_am_first=o_am_last=0.
//  - FSM states IDLE, AM, DATA (registered). Outputs are decoded from state and
//    registers plus i_dst_ready/i_src_valid; zero-cycle ready latency.
//  - IDLE: o_src_ready=0, o_out_valid=0. i_enable=1 -> AM with idx=0 next cycle.
//  - AM: o_am_sel=1, o_src_ready=0, o_out_valid=i_dst_ready.
//    Slot advance = i_dst_ready; idx holds while i_dst_ready=0.
//    On advance at idx=AM_LEN-1: idx->0, o_blk_cnt->0, next state = DATA if
//    i_enable else IDLE. A started burst always completes (never truncated by enable).
//  - DATA: o_am_sel=0, o_src_ready=i_dst_ready, beat = i_src_valid&o_src_ready,
//    o_out_valid=beat. Each beat increments o_blk_cnt.
//    Beat with o_blk_cnt=AM_PERIOD-1 -> AM (cnt wraps to 0 on burst end).
//    i_enable=0 -> IDLE at next edge; a beat in that same cycle is still counted.
//    Simultaneous last-block beat and i_enable=0: IDLE wins, no AM burst.
//  - Re-enable from IDLE always starts with a full AM burst, counter 0.
//  - o_am_first = o_am_sel & idx==0; o_am_last = o_am_sel & idx==AM_LEN-1.
//  - Counter never exceeds AM_PERIOD-1; no idle-gap beats are counted.
//  - Reset mid-burst or mid-period: immediate return to reset values, no flush.
// STRUCTURE
//  - aui_pkg: typedef enum {IDLE, AM, DATA} am_sched_state_t; AUI_NUM_LANES=16;
//    AM_LEN_DEFAULT=16; AM_PERIOD_DEFAULT=40960.
//  - Sub-module am_period_counter: CNT_W counter with inc, clr and terminal-count
//    flag (cnt==AM_PERIOD-1). FSM, slot index and output decode live in the top.
// TESTING (bench with AM_PERIOD=8, AM_LEN=4, dst_ready=1 unless stated)
//  1 Reset then i_enable=1, src_valid=1 -> 4 AM beats idx 0..3 (first@0,last@3),
//    then 8 data beats, cnt 0..7, then next AM burst; pattern repeats.
//  2 Toggle i_dst_ready 1/0 during AM and DATA -> idx/cnt hold on 0 cycles,
//    o_out_valid=0 and o_src_ready=0 while dst_ready=0; no lost/duplicated beats.
//  3 src_valid low for 3 cycles mid-period -> cnt holds, o_out_valid=0; AM only
//    after the 8th accepted block.
//  4 i_enable=0 at AM idx=1 -> idx 2,3 still emitted, then IDLE; re-enable ->
//    AM idx=0 burst, cnt=0.
//  5 i_enable=0 in same cycle as 8th block beat -> beat counted, IDLE, no AM.
//  6 rst_n low mid-DATA (cnt=5) asynchronously -> all outputs 0 same cycle;
//    after release + enable, sequence restarts exactly as scenario 1.

Source files
------------

// File: rtl/aui_pkg.sv
// Shared types and defaults for the AUI transmit alignment-marker logic.
package aui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AM   = 2'd1,
        DATA = 2'd2
    } am_sched_state_t;

    localparam int AUI_NUM_LANES     = 16;
    localparam int AM_LEN_DEFAULT    = 16;
    localparam int AM_PERIOD_DEFAULT = 40960;

endpackage

// File: rtl/am_insertion_scheduler_if.sv
// Handshake bundle between the PCS block source, the AM scheduler and the lane distributor.
interface am_insertion_scheduler_if
    import aui_pkg::*;
#(
    parameter int IDX_W = $clog2(AUI_NUM_LANES),
    parameter int CNT_W = $clog2(AM_PERIOD_DEFAULT)
);
    logic             i_enable;
    logic             i_src_valid;
    logic             o_src_ready;
    logic             i_dst_ready;
    logic             o_out_valid;
    logic             o_am_sel;
    logic [IDX_W-1:0] o_am_idx;
    logic             o_am_first;
    logic             o_am_last;
    logic [CNT_W-1:0] o_blk_cnt;

    modport slave (
        input  i_enable, i_src_valid, i_dst_ready,
        output o_src_ready, o_out_valid, o_am_sel, o_am_idx,
               o_am_first, o_am_last, o_blk_cnt
    );

    modport master (
        output i_enable, i_src_valid, i_dst_ready,
        input  o_src_ready, o_out_valid, o_am_sel, o_am_idx,
               o_am_first, o_am_last, o_blk_cnt
    );
endinterface

// File: rtl/am_period_counter.sv
// Data-block counter for one AM period; saturates at the terminal count until cleared.
module am_period_counter #(
    parameter int AM_PERIOD = 8,
    parameter int CNT_W     = $clog2(AM_PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == CNT_W'(AM_PERIOD - 1));
    assign cnt_o = cnt_q;

    // Holding at the terminal count keeps the value inside the period until the burst clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/am_insertion_scheduler.sv
// Pauses the block source every AM_PERIOD blocks and grants AM_LEN slots to the AM mux.
module am_insertion_scheduler
    import aui_pkg::*;
#(
    parameter int AM_PERIOD = AM_PERIOD_DEFAULT,
    parameter int AM_LEN    = AM_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    am_insertion_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(AM_PERIOD);
    localparam int IDX_W = $clog2(AM_LEN);

    am_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cnt_inc, cnt_clr, cnt_tc;
    logic [CNT_W-1:0] cnt;
    logic             src_ready, out_valid, am_sel, idx_last;

    am_period_counter #(
        .AM_PERIOD (AM_PERIOD),
        .CNT_W     (CNT_W)
    ) u_period_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    assign idx_last = (idx_q == IDX_W'(AM_LEN - 1));

    // A started burst runs to its last slot regardless of enable; IDLE beats AM on a last-block beat.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        src_ready = 1'b0;
        out_valid = 1'b0;
        am_sel    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_enable) begin
                    state_d = AM;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            AM: begin
                am_sel    = 1'b1;
                out_valid = bus.i_dst_ready;
                if (bus.i_dst_ready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        cnt_clr = 1'b1;
                        state_d = bus.i_enable ? DATA : IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DATA: begin
                src_ready = bus.i_dst_ready;
                out_valid = bus.i_src_valid & bus.i_dst_ready;
                cnt_inc   = out_valid;
                if (!bus.i_enable) begin
                    state_d = IDLE;
                end else if (out_valid && cnt_tc) begin
                    state_d = AM;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.o_src_ready = src_ready;
    assign bus.o_out_valid = out_valid;
    assign bus.o_am_sel    = am_sel;
    assign bus.o_am_idx    = idx_q;
    assign bus.o_am_first  = am_sel & (idx_q == '0);
    assign bus.o_am_last   = am_sel & idx_last;
    assign bus.o_blk_cnt   = cnt;
endmodule

// File: tb/tb_am_insertion_scheduler.sv
// Directed vector bench for am_insertion_scheduler with AM_PERIOD=8, AM_LEN=4.
module tb_am_insertion_scheduler;

    localparam int AM_PERIOD = 8;
    localparam int AM_LEN    = 4;
    localparam int CNT_W     = 3;
    localparam int IDX_W     = 2;

    typedef struct {
        logic en, sv, dr;
        logic rdy, val, sel;
        int   idx;
        logic first, last;
        int   cnt;
        bit   cntChk;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   curVec = 0;
    vec_t vecs[$];

    am_insertion_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    am_insertion_scheduler #(
        .AM_PERIOD (AM_PERIOD),
        .AM_LEN    (AM_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (vector %0d): got %0d, expected %0d", name, curVec, act, exp);
        end
    endtask

    task automatic addVec(input logic en, input logic sv, input logic dr,
                          input logic rdy, input logic val, input logic sel,
                          input int idx, input int cnt, input bit cntChk);
        vec_t v;
        v.en = en; v.sv = sv; v.dr = dr;
        v.rdy = rdy; v.val = val; v.sel = sel; v.idx = idx;
        v.first = sel && (idx == 0);
        v.last  = sel && (idx == AM_LEN - 1);
        v.cnt = cnt; v.cntChk = cntChk;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input logic en, input int cnt, input bit cntChk);
        addVec(en, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, cnt, cntChk);
    endtask

    task automatic addAm(input logic en, input logic dr, input int idx, input int cnt, input bit cntChk);
        addVec(en, 1'b1, dr, 1'b0, dr, 1'b1, idx, cnt, cntChk);
    endtask

    task automatic addData(input logic en, input logic sv, input logic dr, input int cnt);
        addVec(en, sv, dr, dr, sv & dr, 1'b0, 0, cnt, 1'b1);
    endtask

    task automatic checkOutput(input vec_t v);
        checkField("src_ready", int'(bus.o_src_ready), int'(v.rdy));
        checkField("out_valid", int'(bus.o_out_valid), int'(v.val));
        checkField("am_sel",    int'(bus.o_am_sel),    int'(v.sel));
        checkField("am_idx",    int'(bus.o_am_idx),    v.idx);
        checkField("am_first",  int'(bus.o_am_first),  int'(v.first));
        checkField("am_last",   int'(bus.o_am_last),   int'(v.last));
        if (v.cntChk) checkField("blk_cnt", int'(bus.o_blk_cnt), v.cnt);
    endtask

    // Called just after a rising edge: drive, check mid-cycle, then step past the next edge.
    task automatic applyStimulus(input int i);
        curVec = i;
        bus.i_enable    = vecs[i].en;
        bus.i_src_valid = vecs[i].sv;
        bus.i_dst_ready = vecs[i].dr;
        @(negedge clk);
        checkOutput(vecs[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        curVec = -1;
        checkField({tag, "_src_ready"}, int'(bus.o_src_ready), 0);
        checkField({tag, "_out_valid"}, int'(bus.o_out_valid), 0);
        checkField({tag, "_am_sel"},    int'(bus.o_am_sel),    0);
        checkField({tag, "_am_idx"},    int'(bus.o_am_idx),    0);
        checkField({tag, "_am_first"},  int'(bus.o_am_first),  0);
        checkField({tag, "_am_last"},   int'(bus.o_am_last),   0);
        checkField({tag, "_blk_cnt"},   int'(bus.o_blk_cnt),   0);
    endtask

    initial begin
        int s1Len;

        // Scenario 1: start-up burst, one full period, second burst.
        addIdle(1'b1, 0, 1'b1);
        for (int i = 0; i < AM_LEN; i++) addAm(1'b1, 1'b1, i, 0, 1'b1);
        for (int k = 0; k < AM_PERIOD; k++) addData(1'b1, 1'b1, 1'b1, k);
        s1Len = vecs.size();
        for (int i = 0; i < AM_LEN; i++) addAm(1'b1, 1'b1, i, 0, 1'b0);
        addData(1'b1, 1'b1, 1'b1, 0);
        addData(1'b1, 1'b1, 1'b1, 1);

        // Scenario 2: downstream back-pressure in DATA.
        addData(1'b1, 1'b1, 1'b0, 2);
        addData(1'b1, 1'b1, 1'b1, 2);
        addData(1'b1, 1'b1, 1'b0, 3);
        addData(1'b1, 1'b1, 1'b1, 3);

        // Scenario 3: source gap, then back-pressure inside the burst.
        for (int k = 0; k < 3; k++) addData(1'b1, 1'b0, 1'b1, 4);
        for (int k = 4; k < AM_PERIOD; k++) addData(1'b1, 1'b1, 1'b1, k);
        addAm(1'b1, 1'b0, 0, 0, 1'b0);
        addAm(1'b1, 1'b1, 0, 0, 1'b0);
        addAm(1'b1, 1'b0, 1, 0, 1'b0);
        addAm(1'b1, 1'b1, 1, 0, 1'b0);
        addAm(1'b1, 1'b1, 2, 0, 1'b0);
        addAm(1'b1, 1'b1, 3, 0, 1'b0);
        for (int k = 0; k < AM_PERIOD; k++) addData(1'b1, 1'b1, 1'b1, k);

        // Scenario 4: disable at idx 1 completes the burst, then IDLE, then re-enable.
        addAm(1'b1, 1'b1, 0, 0, 1'b0);
        addAm(1'b0, 1'b1, 1, 0, 1'b0);
        addAm(1'b0, 1'b1, 2, 0, 1'b0);
        addAm(1'b0, 1'b1, 3, 0, 1'b0);
        addIdle(1'b0, 0, 1'b1);
        addIdle(1'b0, 0, 1'b1);
        addIdle(1'b1, 0, 1'b1);
        for (int i = 0; i < AM_LEN; i++) addAm(1'b1, 1'b1, i, 0, 1'b1);

        // Scenario 5: disable together with the last block of the period.
        for (int k = 0; k < AM_PERIOD - 1; k++) addData(1'b1, 1'b1, 1'b1, k);
        addData(1'b0, 1'b1, 1'b1, AM_PERIOD - 1);
        addIdle(1'b0, 0, 1'b0);
        addIdle(1'b0, 0, 1'b0);
        addIdle(1'b1, 0, 1'b0);
        for (int i = 0; i < AM_LEN; i++) addAm(1'b1, 1'b1, i, 0, 1'b1);
        for (int k = 0; k < 5; k++) addData(1'b1, 1'b1, 1'b1, k);

        rst_n = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_src_valid = 1'b0;
        bus.i_dst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

        // Scenario 6: asynchronous reset in the middle of a period (cnt=5).
        bus.i_enable = 1'b1;
        bus.i_src_valid = 1'b1;
        bus.i_dst_ready = 1'b1;
        #2;
        curVec = -2;
        checkField("pre_reset_cnt",   int'(bus.o_blk_cnt),   5);
        checkField("pre_reset_valid", int'(bus.o_out_valid), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < s1Len; i++) applyStimulus(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
